// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine feeding the video-memory write port: clips a command
// to the frame and emits one byte write per unstalled cycle in row-major order.
module vram_rect_fill #(
  parameter int ROW_BYTES = 320,
  parameter int ROWS      = 480,
  parameter int AW        = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [8:0]    cmd_x,
  input  logic [8:0]    cmd_y,
  input  logic [8:0]    cmd_w,
  input  logic [8:0]    cmd_h,
  input  logic [7:0]    cmd_color,
  input  logic          stall,
  input  logic          abort,
  output logic [AW-1:0] vmem_addr,
  output logic [7:0]    vmem_data,
  output logic          vmem_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] row_base;
  logic [AW-1:0] origin;
  logic [9:0]    col_cnt, row_cnt;
  logic [9:0]    col_last, row_last;
  logic [9:0]    x_ext, y_ext, w_ext, h_ext;
  logic [9:0]    x_room, y_room;
  logic [9:0]    w_clip, h_clip;
  logic          cmd_take, cmd_empty;
  logic          col_end, row_end;

  // Command decode and clipping; room values are only meaningful when not empty.
  always_comb begin
    x_ext     = {1'b0, cmd_x};
    y_ext     = {1'b0, cmd_y};
    w_ext     = {1'b0, cmd_w};
    h_ext     = {1'b0, cmd_h};
    x_room    = 10'(ROW_BYTES) - x_ext;
    y_room    = 10'(ROWS) - y_ext;
    w_clip    = (w_ext < x_room) ? w_ext : x_room;
    h_clip    = (h_ext < y_room) ? h_ext : y_room;
    cmd_empty = (x_ext >= 10'(ROW_BYTES)) || (y_ext >= 10'(ROWS)) ||
                (cmd_w == 9'd0) || (cmd_h == 9'd0);
    cmd_take  = cmd_valid && (state == IDLE);
  end

  // Origin address y*ROW_BYTES + x; the 320-byte frame decomposes into two shifts.
  generate
    if (ROW_BYTES == 320) begin : g_origin_shift
      assign origin = AW'({cmd_y, 8'b0}) + AW'({cmd_y, 6'b0}) + AW'(cmd_x);
    end else begin : g_origin_generic
      assign origin = AW'(cmd_y) * AW'(ROW_BYTES) + AW'(cmd_x);
    end
  endgenerate

  assign col_end = (col_cnt == col_last);
  assign row_end = (row_cnt == row_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    vmem_we    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_next = cmd_empty ? DONE : FILL;
        end
      end
      FILL: begin
        vmem_we = !stall && !abort;
        if (abort) begin
          state_next = DONE;
        end else if (!stall && col_end && row_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vmem_addr <= '0;
      vmem_data <= '0;
      row_base  <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      col_last  <= '0;
      row_last  <= '0;
    end else if (cmd_take && !cmd_empty) begin
      vmem_addr <= origin;
      row_base  <= origin;
      vmem_data <= cmd_color;
      col_cnt   <= '0;
      row_cnt   <= '0;
      col_last  <= w_clip - 10'd1;
      row_last  <= h_clip - 10'd1;
    end else if (vmem_we) begin
      if (!col_end) begin
        vmem_addr <= vmem_addr + AW'(1);
        col_cnt   <= col_cnt + 10'd1;
      end else if (!row_end) begin
        vmem_addr <= row_base + AW'(ROW_BYTES);
        row_base  <= row_base + AW'(ROW_BYTES);
        col_cnt   <= '0;
        row_cnt   <= row_cnt + 10'd1;
      end
    end
  end

  a_in_frame: assert property (@(posedge clk) disable iff (!rst)
    vmem_we |-> (vmem_addr < AW'(ROW_BYTES * ROWS)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
    done |=> !done);

endmodule

// File: tb/tb_vram_rect_fill.sv
// Scoreboard bench for vram_rect_fill: expected writes are queued per command
// and consumed by a write monitor; each scenario task checks its own timing.
module tb_vram_rect_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic [19:0] vmem_addr;
  logic [7:0]  vmem_data;
  logic        vmem_we;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;
  logic [27:0] sb[$];
  logic [27:0] mon_exp;

  vram_rect_fill #(.ROW_BYTES(320), .ROWS(480), .AW(20)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .stall(stall), .abort(abort),
    .vmem_addr(vmem_addr), .vmem_data(vmem_data), .vmem_we(vmem_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && vmem_we === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write", vmem_addr, vmem_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({vmem_addr, vmem_data} !== mon_exp) begin
          n_mis++;
          $display("FAIL write_value: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   vmem_addr, vmem_data, mon_exp[27:8], mon_exp[7:0]);
        end
      end
    end
  end

  // Reference model of the clipped fill; pushes every expected write.
  task automatic push_model(input int x, input int y, input int w, input int h,
                            input logic [7:0] c, output int n);
    int wc, hc;
    n = 0;
    if (x >= 320 || y >= 480 || w == 0 || h == 0) return;
    wc = (w < 320 - x) ? w : 320 - x;
    hc = (h < 480 - y) ? h : 480 - y;
    for (int r = 0; r < hc; r++)
      for (int col = 0; col < wc; col++) begin
        sb.push_back({20'((y + r) * 320 + x + col), c});
        n++;
      end
  endtask

  task automatic do_cmd(input int x, input int y, input int w, input int h,
                        input logic [7:0] c, input int stall_mask, input int abort_k,
                        input int limit, output int n_we, output int done_k,
                        output int n_done, output int ready_k, output int busy_n);
    n_we = 0; done_k = -1; n_done = 0; ready_k = -1; busy_n = 0;
    @(posedge clk); #1;
    cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 9'(w); cmd_h = 9'(h); cmd_color = c;
    cmd_valid = 1'b1; stall = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL cmd_ready_at_accept: got %b, required 1", cmd_ready);
    end
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      // Valid stays high with a different command to show it is ignored while busy.
      cmd_x = 9'd0; cmd_y = 9'd0; cmd_w = 9'd1; cmd_h = 9'd1; cmd_color = 8'hEE;
      stall = (k < 32) ? stall_mask[k] : 1'b0;
      abort = (k == abort_k);
      @(negedge clk);
      if (vmem_we === 1'b1) n_we++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (cmd_ready === 1'b1) begin
        ready_k = k;
        cmd_valid = 1'b0; stall = 1'b0; abort = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0; stall = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (cmd_ready !== 1'b1) begin n_mis++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
    if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b, required 0", done); end
    if (vmem_we !== 1'b0) begin n_mis++; $display("FAIL rst_we: got %b, required 0", vmem_we); end
    if (vmem_addr !== 20'd0) begin n_mis++; $display("FAIL rst_addr: got %0d, required 0", vmem_addr); end
    if (vmem_data !== 8'd0) begin n_mis++; $display("FAIL rst_data: got %02h, required 00", vmem_data); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (cmd_ready !== 1'b1) begin n_mis++; $display("FAIL post_rst_ready: got %b, required 1", cmd_ready); end
    if (busy !== 1'b0) begin n_mis++; $display("FAIL post_rst_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic();
    int n_we, done_k, n_done, ready_k, busy_n;
    int exp_addr[6] = '{650, 651, 652, 970, 971, 972};
    foreach (exp_addr[i]) sb.push_back({20'(exp_addr[i]), 8'hA5});
    do_cmd(10, 2, 3, 2, 8'hA5, 0, -1, 30, n_we, done_k, n_done, ready_k, busy_n);
    n_cmp += 6;
    if (n_we !== 6) begin n_mis++; $display("FAIL basic_writes: got %0d, required 6", n_we); end
    if (done_k !== 7) begin n_mis++; $display("FAIL basic_done: got T+%0d, required T+7", done_k); end
    if (n_done !== 1) begin n_mis++; $display("FAIL basic_done_count: got %0d, required 1", n_done); end
    if (ready_k !== 8) begin n_mis++; $display("FAIL basic_ready: got T+%0d, required T+8", ready_k); end
    if (busy_n !== 7) begin n_mis++; $display("FAIL basic_busy: got %0d, required 7", busy_n); end
    if (sb.size() !== 0) begin n_mis++; $display("FAIL basic_missing: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_clip();
    int n_we, done_k, n_done, ready_k, busy_n;
    sb.push_back({20'd153598, 8'h3C});
    sb.push_back({20'd153599, 8'h3C});
    do_cmd(318, 479, 5, 4, 8'h3C, 0, -1, 30, n_we, done_k, n_done, ready_k, busy_n);
    n_cmp += 4;
    if (n_we !== 2) begin n_mis++; $display("FAIL clip_writes: got %0d, required 2", n_we); end
    if (done_k !== 3) begin n_mis++; $display("FAIL clip_done: got T+%0d, required T+3", done_k); end
    if (ready_k !== 4) begin n_mis++; $display("FAIL clip_ready: got T+%0d, required T+4", ready_k); end
    if (sb.size() !== 0) begin n_mis++; $display("FAIL clip_missing: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_empty();
    int n_we, done_k, n_done, ready_k, busy_n;
    int xs[2] = '{5, 320};
    int ws[2] = '{0, 4};
    for (int i = 0; i < 2; i++) begin
      do_cmd(xs[i], 7, ws[i], 3, 8'h99, 0, -1, 20, n_we, done_k, n_done, ready_k, busy_n);
      n_cmp += 4;
      if (n_we !== 0) begin n_mis++; $display("FAIL empty%0d_writes: got %0d, required 0", i, n_we); end
      if (done_k !== 1) begin n_mis++; $display("FAIL empty%0d_done: got T+%0d, required T+1", i, done_k); end
      if (ready_k !== 2) begin n_mis++; $display("FAIL empty%0d_ready: got T+%0d, required T+2", i, ready_k); end
      if (busy_n !== 1) begin n_mis++; $display("FAIL empty%0d_busy: got %0d, required 1", i, busy_n); end
    end
  endtask

  task automatic test_stall();
    int n_we, done_k, n_done, ready_k, busy_n;
    for (int a = 0; a < 4; a++) sb.push_back({20'(a), 8'h5A});
    do_cmd(0, 0, 4, 1, 8'h5A, (1 << 2) | (1 << 3), -1, 30, n_we, done_k, n_done, ready_k, busy_n);
    n_cmp += 4;
    if (n_we !== 4) begin n_mis++; $display("FAIL stall_writes: got %0d, required 4", n_we); end
    if (done_k !== 7) begin n_mis++; $display("FAIL stall_done: got T+%0d, required T+7", done_k); end
    if (ready_k !== 8) begin n_mis++; $display("FAIL stall_ready: got T+%0d, required T+8", ready_k); end
    if (sb.size() !== 0) begin n_mis++; $display("FAIL stall_missing: got %0d left, required 0", sb.size()); end
  endtask

  // Abort on the 3rd write cycle, with stall also high there: abort must win.
  task automatic test_abort();
    int n_we, done_k, n_done, ready_k, busy_n;
    sb.push_back({20'd1620, 8'h77});
    sb.push_back({20'd1621, 8'h77});
    do_cmd(20, 5, 10, 10, 8'h77, (1 << 3), 3, 30, n_we, done_k, n_done, ready_k, busy_n);
    n_cmp += 5;
    if (n_we !== 2) begin n_mis++; $display("FAIL abort_writes: got %0d, required 2", n_we); end
    if (done_k !== 4) begin n_mis++; $display("FAIL abort_done: got T+%0d, required T+4", done_k); end
    if (n_done !== 1) begin n_mis++; $display("FAIL abort_done_count: got %0d, required 1", n_done); end
    if (ready_k !== 5) begin n_mis++; $display("FAIL abort_ready: got T+%0d, required T+5", ready_k); end
    if (sb.size() !== 0) begin n_mis++; $display("FAIL abort_missing: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int n_model, n_before, n_we, done_k, n_done, ready_k, busy_n;
    n_before = 0;
    push_model(0, 0, 10, 10, 8'h11, n_model);
    @(posedge clk); #1;
    cmd_x = 9'd0; cmd_y = 9'd0; cmd_w = 9'd10; cmd_h = 9'd10; cmd_color = 8'h11;
    cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk); if (vmem_we === 1'b1) n_before++;
    @(negedge clk); if (vmem_we === 1'b1) n_before++;
    @(posedge clk); #2; rst = 1'b0; #1;
    n_cmp += 2;
    if (vmem_we !== 1'b0) begin n_mis++; $display("FAIL rstmid_we_drop: got %b, required 0", vmem_we); end
    if (n_before !== 2) begin n_mis++; $display("FAIL rstmid_writes_before: got %0d, required 2", n_before); end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (done !== 1'b0) begin n_mis++; $display("FAIL rstmid_done%0d: got %b, required 0", i, done); end
      if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_busy%0d: got %b, required 0", i, busy); end
    end
    @(posedge clk); #1; rst = 1'b1;
    sb.push_back({20'd0, 8'h42});
    do_cmd(0, 0, 1, 1, 8'h42, 0, -1, 20, n_we, done_k, n_done, ready_k, busy_n);
    n_cmp += 4;
    if (n_we !== 1) begin n_mis++; $display("FAIL rstmid_new_writes: got %0d, required 1", n_we); end
    if (done_k !== 2) begin n_mis++; $display("FAIL rstmid_new_done: got T+%0d, required T+2", done_k); end
    if (ready_k !== 3) begin n_mis++; $display("FAIL rstmid_new_ready: got T+%0d, required T+3", ready_k); end
    if (sb.size() !== 0) begin n_mis++; $display("FAIL rstmid_missing: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int x, y, w, h, n, n_we, done_k, n_done, ready_k, busy_n;
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 330);
      y = (i % 2 == 0) ? $urandom_range(470, 490) : $urandom_range(0, 479);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 4);
      c = 8'($urandom);
      push_model(x, y, w, h, c, n);
      do_cmd(x, y, w, h, c, 0, -1, n + 20, n_we, done_k, n_done, ready_k, busy_n);
      n_cmp += 4;
      if (n_we !== n) begin n_mis++; $display("FAIL b2b%0d_writes: got %0d, required %0d", i, n_we, n); end
      if (done_k !== n + 1) begin n_mis++; $display("FAIL b2b%0d_done: got T+%0d, required T+%0d", i, done_k, n + 1); end
      if (ready_k !== n + 2) begin n_mis++; $display("FAIL b2b%0d_ready: got T+%0d, required T+%0d", i, ready_k, n + 2); end
      if (sb.size() !== 0) begin n_mis++; $display("FAIL b2b%0d_missing: got %0d left, required 0", i, sb.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_stall();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required run completion");
    $fatal(1, "watchdog expired");
  end

endmodule
